// File: rtl/traffic_junction.sv
// Traffic junction controller: N_WAY approaches, fixed or demand-actuated, with pedestrian phase.
// Latency: lamps and phase are registered and follow the state register in the same cycle.
// No backpressure. A pedestrian request is latched and served at the next all-red clearance.
module traffic_junction #(
  parameter int N_WAY       = 2,
  parameter int T_GREEN     = 8,
  parameter int T_AMBER     = 3,
  parameter int T_RED_AMBER = 2,
  parameter int T_ALL_RED   = 2,
  parameter int T_PED       = 6,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [N_WAY-1:0] demand,
  input  logic             ped_req,
  output logic [N_WAY-1:0] red,
  output logic [N_WAY-1:0] amber,
  output logic [N_WAY-1:0] green,
  output logic             walk,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    ST_ALL_RED   = 3'd0,
    ST_RED_AMBER = 3'd1,
    ST_GREEN     = 3'd2,
    ST_AMBER     = 3'd3,
    ST_PED       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_GREEN     = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] C_AMBER     = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] C_RED_AMBER = CNT_W'(T_RED_AMBER - 1);
  localparam logic [CNT_W-1:0] C_ALL_RED   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] C_PED       = CNT_W'(T_PED - 1);
  localparam logic [N_WAY-1:0] ONE_HOT0    = N_WAY'(1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic [N_WAY-1:0] red_q, red_d, amber_q, amber_d, green_q, green_d;
  logic             walk_q, walk_d;
  logic [2:0]       phase_q, phase_d;
  logic [N_WAY-1:0] sel;
  logic             found;
  logic [1:0]       srch_ptr;

  // Approach index p+k wrapped to the real number of approaches, not to 4.
  function automatic logic [1:0] wrap_add(input logic [1:0] p, input int k);
    int s;
    s = (int'(p) + k) % N_WAY;
    return 2'(s);
  endfunction

  // Demand search: first requesting approach after ptr, wrapping round to ptr itself last.
  always_comb begin
    found    = 1'b0;
    srch_ptr = ptr_q;
    for (int i = 1; i <= N_WAY; i++) begin
      if (!found && demand[wrap_add(ptr_q, i)]) begin
        found    = 1'b1;
        srch_ptr = wrap_add(ptr_q, i);
      end
    end
  end

  // Next state, pointer, dwell counter and pedestrian latch.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    ped_pending_d = ped_pending_q | (ped_req && (state_q != ST_PED));
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      case (state_q)
        ST_ALL_RED: begin
          if (ped_pending_q) begin
            // Entering PED consumes the request; a same-cycle request is dropped.
            state_d       = ST_PED;
            cnt_d         = C_PED;
            ped_pending_d = 1'b0;
          end else if (!mode) begin
            ptr_d   = wrap_add(ptr_q, 1);
            state_d = ST_RED_AMBER;
            cnt_d   = C_RED_AMBER;
          end else if (found) begin
            ptr_d   = srch_ptr;
            state_d = ST_RED_AMBER;
            cnt_d   = C_RED_AMBER;
          end else begin
            // Nobody waiting: park in all-red and look again next cycle.
            cnt_d = '0;
          end
        end
        ST_RED_AMBER: begin
          state_d = ST_GREEN;
          cnt_d   = C_GREEN;
        end
        ST_GREEN: begin
          state_d = ST_AMBER;
          cnt_d   = C_AMBER;
        end
        ST_AMBER, ST_PED: begin
          state_d = ST_ALL_RED;
          cnt_d   = C_ALL_RED;
        end
        default: begin
          state_d = ST_ALL_RED;
          cnt_d   = C_ALL_RED;
        end
      endcase
    end
  end

  // Lamp decode from the next state so the registered lamps line up with the state register.
  always_comb begin
    sel     = ONE_HOT0 << ptr_d;
    red_d   = '1;
    amber_d = '0;
    green_d = '0;
    walk_d  = 1'b0;
    phase_d = state_d;
    case (state_d)
      ST_RED_AMBER: amber_d = sel;
      ST_GREEN: begin
        red_d   = ~sel;
        green_d = sel;
      end
      ST_AMBER: begin
        red_d   = ~sel;
        amber_d = sel;
      end
      ST_PED:   walk_d = 1'b1;
      default:  red_d = '1;
    endcase
  end

  // State and lamp registers; reset forces all-red immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ALL_RED;
      ptr_q         <= 2'(N_WAY - 1);
      cnt_q         <= C_ALL_RED;
      ped_pending_q <= 1'b0;
      red_q         <= '1;
      amber_q       <= '0;
      green_q       <= '0;
      walk_q        <= 1'b0;
      phase_q       <= 3'd0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      red_q         <= red_d;
      amber_q       <= amber_d;
      green_q       <= green_d;
      walk_q        <= walk_d;
      phase_q       <= phase_d;
    end
  end

  assign red   = red_q;
  assign amber = amber_q;
  assign green = green_q;
  assign walk  = walk_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_junction.sv
// Directed bench for traffic_junction: a 2-way and a 4-way instance.
// Samples 1 time unit after each rising edge; invariants checked on every falling edge.
// Expected lamp sequences come from hand-derived phase timelines.
module tb_traffic_junction;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2, mode2, ped2;
  logic [1:0] dem2, red2, amb2, grn2;
  logic       walk2;
  logic [2:0] ph2;

  logic       rst4, mode4, ped4;
  logic [3:0] dem4, red4, amb4, grn4;
  logic       walk4;
  logic [2:0] ph4;

  int checks = 0;
  int errors = 0;

  traffic_junction #(.N_WAY(2)) dut2 (
    .clk(clk), .rst(rst2), .mode(mode2), .demand(dem2), .ped_req(ped2),
    .red(red2), .amber(amb2), .green(grn2), .walk(walk2), .phase(ph2)
  );

  traffic_junction #(.N_WAY(4)) dut4 (
    .clk(clk), .rst(rst4), .mode(mode4), .demand(dem4), .ped_req(ped4),
    .red(red4), .amber(amb4), .green(grn4), .walk(walk4), .phase(ph4)
  );

  // Safety invariants on both instances every cycle.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(grn2) || ((grn2 & red2) != 2'b00) || (walk2 && grn2 != 2'b00)) begin
      errors++;
      $display("FAIL invariant2 t=%0t green=%b red=%b walk=%b required onehot0 green, green&red=0, walk->green=0",
               $time, grn2, red2, walk2);
    end
    checks++;
    if (!$onehot0(grn4) || ((grn4 & red4) != 4'b0000) || (walk4 && grn4 != 4'b0000)) begin
      errors++;
      $display("FAIL invariant4 t=%0t green=%b red=%b walk=%b required onehot0 green, green&red=0, walk->green=0",
               $time, grn4, red4, walk4);
    end
  end

  // Fixed round-robin timeline: sample s after reset release -> phase and approach.
  function automatic void model_fixed(input int s, input int n, output int ph, output int p);
    int u;
    if (s < 2) begin
      ph = 0; p = n - 1;
    end else begin
      u = (s - 2) % 15;
      p = ((s - 2) / 15) % n;
      if (u < 2)       ph = 1;
      else if (u < 10) ph = 2;
      else if (u < 13) ph = 3;
      else             ph = 0;
    end
  endfunction

  // Lamp pattern for a phase on approach p (4-bit, caller masks to width).
  function automatic void lamps(input int ph, input int p, output logic [3:0] r,
                                output logic [3:0] a, output logic [3:0] g, output logic w);
    logic [3:0] sel;
    sel = 4'b0001 << p;
    r = 4'b1111; a = 4'b0000; g = 4'b0000; w = 1'b0;
    case (ph)
      1: a = sel;
      2: begin r = ~sel; g = sel; end
      3: begin r = ~sel; a = sel; end
      4: w = 1'b1;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset2();
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst4 = 1'b1;
    #1;
    checks++;
    if (ph2 !== 3'd0 || red2 !== 2'b11 || amb2 !== 2'b00 || grn2 !== 2'b00 || walk2 !== 1'b0) begin
      errors++;
      $display("FAIL reset2 phase=%0d red=%b amber=%b green=%b walk=%b required 0 11 00 00 0",
               ph2, red2, amb2, grn2, walk2);
    end
    checks++;
    if (ph4 !== 3'd0 || red4 !== 4'b1111 || amb4 !== 4'b0000 || grn4 !== 4'b0000 || walk4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4 phase=%0d red=%b amber=%b green=%b walk=%b required 0 1111 0000 0000 0",
               ph4, red4, amb4, grn4, walk4);
    end
  endtask

  // 2-way round robin over a little more than one 30-cycle period.
  task automatic test_fixed2();
    int ph, p;
    logic [3:0] r, a, g;
    logic w;
    mode2 = 1'b0; ped2 = 1'b0; dem2 = 2'b00;
    reset2();
    for (int s = 0; s <= 34; s++) begin
      if (s > 0) tick();
      model_fixed(s, 2, ph, p);
      lamps(ph, p, r, a, g, w);
      checks++;
      if (ph2 !== 3'(ph) || red2 !== r[1:0] || amb2 !== a[1:0] || grn2 !== g[1:0] || walk2 !== w) begin
        errors++;
        $display("FAIL fixed2 s=%0d phase=%0d red=%b amber=%b green=%b walk=%b required %0d %b %b %b %b",
                 s, ph2, red2, amb2, grn2, walk2, ph, r[1:0], a[1:0], g[1:0], w);
      end
    end
  endtask

  // Pedestrian pulse during approach 0 green, served after the following clearance.
  task automatic test_ped_pulse();
    int ph, p;
    logic [3:0] r, a, g;
    logic w;
    mode2 = 1'b0; ped2 = 1'b0;
    reset2();
    for (int s = 0; s <= 27; s++) begin
      if (s > 0) tick();
      if (s >= 17 && s <= 22)      begin ph = 4; p = 0; end
      else if (s == 23 || s == 24) begin ph = 0; p = 0; end
      else if (s >= 25)            model_fixed(s - 8, 2, ph, p);
      else                         model_fixed(s, 2, ph, p);
      lamps(ph, p, r, a, g, w);
      checks++;
      if (ph2 !== 3'(ph) || red2 !== r[1:0] || amb2 !== a[1:0] || grn2 !== g[1:0] || walk2 !== w) begin
        errors++;
        $display("FAIL ped_pulse s=%0d phase=%0d red=%b amber=%b green=%b walk=%b required %0d %b %b %b %b",
                 s, ph2, red2, amb2, grn2, walk2, ph, r[1:0], a[1:0], g[1:0], w);
      end
      if (s == 6) ped2 = 1'b1;
      if (s == 7) ped2 = 1'b0;
    end
  endtask

  // Pedestrian request held: PED after every clearance, no re-arm while walking.
  task automatic test_ped_held();
    int ph;
    mode2 = 1'b0; ped2 = 1'b1;
    reset2();
    for (int s = 0; s <= 15; s++) begin
      if (s > 0) tick();
      ph = ((s >= 2 && s <= 7) || s >= 10) ? 4 : 0;
      checks++;
      if (ph2 !== 3'(ph) || walk2 !== (ph == 4) || red2 !== 2'b11) begin
        errors++;
        $display("FAIL ped_held s=%0d phase=%0d walk=%b red=%b required %0d %b 11",
                 s, ph2, walk2, red2, ph, (ph == 4));
      end
    end
    ped2 = 1'b0;
  endtask

  // Reset hitting the third green cycle clears lamps without a clock edge.
  task automatic test_reset_mid();
    int ph, p;
    logic [3:0] r, a, g;
    logic w;
    mode2 = 1'b0; ped2 = 1'b0;
    reset2();
    for (int s = 1; s <= 6; s++) tick();
    checks++;
    if (ph2 !== 3'd2 || grn2 !== 2'b01) begin
      errors++;
      $display("FAIL mid_green phase=%0d green=%b required 2 01", ph2, grn2);
    end
    rst2 = 1'b1;
    #1;
    checks++;
    if (ph2 !== 3'd0 || red2 !== 2'b11 || grn2 !== 2'b00 || amb2 !== 2'b00 || walk2 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset phase=%0d red=%b green=%b amber=%b walk=%b required 0 11 00 00 0",
               ph2, red2, grn2, amb2, walk2);
    end
    reset2();
    for (int s = 0; s <= 6; s++) begin
      if (s > 0) tick();
      model_fixed(s, 2, ph, p);
      lamps(ph, p, r, a, g, w);
      checks++;
      if (ph2 !== 3'(ph) || red2 !== r[1:0] || amb2 !== a[1:0] || grn2 !== g[1:0]) begin
        errors++;
        $display("FAIL restart s=%0d phase=%0d red=%b amber=%b green=%b required %0d %b %b %b",
                 s, ph2, red2, amb2, grn2, ph, r[1:0], a[1:0], g[1:0]);
      end
    end
  endtask

  // 4-way round robin: pointer visits 0,1,2,3 and wraps back to 0.
  task automatic test_wrap4();
    int ph, p;
    logic [3:0] r, a, g;
    logic w;
    mode4 = 1'b0; ped4 = 1'b0; dem4 = 4'b0000;
    reset4();
    for (int s = 0; s <= 66; s++) begin
      if (s > 0) tick();
      model_fixed(s, 4, ph, p);
      lamps(ph, p, r, a, g, w);
      checks++;
      if (ph4 !== 3'(ph) || red4 !== r || amb4 !== a || grn4 !== g || walk4 !== w) begin
        errors++;
        $display("FAIL wrap4 s=%0d phase=%0d red=%b amber=%b green=%b walk=%b required %0d %b %b %b %b",
                 s, ph4, red4, amb4, grn4, walk4, ph, r, a, g, w);
      end
    end
  endtask

  // Demand mode: only approach 3 asks, then nobody, then approach 1.
  task automatic test_demand4();
    int ph, p;
    logic [3:0] r, a, g;
    logic w;
    mode4 = 1'b1; ped4 = 1'b0; dem4 = 4'b1000;
    reset4();
    for (int s = 0; s <= 42; s++) begin
      if (s > 0) tick();
      p = 3;
      if (s < 2)                     ph = 0;
      else if (s < 4)                ph = 1;
      else if (s < 12)               ph = 2;
      else if (s < 15)               ph = 3;
      else if (s < 17)               ph = 0;
      else if (s < 19)               ph = 1;
      else if (s < 27)               ph = 2;
      else if (s < 30)               ph = 3;
      else if (s < 41)               ph = 0;
      else begin ph = 1; p = 1; end
      lamps(ph, p, r, a, g, w);
      checks++;
      if (ph4 !== 3'(ph) || red4 !== r || amb4 !== a || grn4 !== g || walk4 !== w) begin
        errors++;
        $display("FAIL demand4 s=%0d phase=%0d red=%b amber=%b green=%b walk=%b required %0d %b %b %b %b",
                 s, ph4, red4, amb4, grn4, walk4, ph, r, a, g, w);
      end
      // mode/demand wiggles inside a phase must not disturb it.
      if (s == 5)  mode4 = 1'b0;
      if (s == 12) mode4 = 1'b1;
      if (s == 20) dem4 = 4'b0000;
      if (s == 40) dem4 = 4'b0010;
    end
  endtask

  initial begin
    rst2 = 1'b1; mode2 = 1'b0; ped2 = 1'b0; dem2 = 2'b00;
    rst4 = 1'b1; mode4 = 1'b0; ped4 = 1'b0; dem4 = 4'b0000;
    test_reset();
    test_fixed2();
    test_ped_pulse();
    test_ped_held();
    test_reset_mid();
    test_wrap4();
    test_demand4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_junction.md
TRAFFIC_JUNCTION -- requirements
Module: traffic_junction

Interface
REQ-001 Parameter N_WAY, default 2, number of approaches, legal range 2..4.
REQ-002 Parameter T_GREEN, default 8, green duration in clk cycles, minimum 1.
REQ-003 Parameter T_AMBER, default 3, amber duration in cycles, minimum 1.
REQ-004 Parameter T_RED_AMBER, default 2, red+amber duration in cycles, minimum 1.
REQ-005 Parameter T_ALL_RED, default 2, all-red clearance duration in cycles, minimum 1.
REQ-006 Parameter T_PED, default 6, pedestrian walk duration in cycles, minimum 1.
REQ-007 Parameter CNT_W, default 8, dwell-counter width; every T_* parameter SHALL be at most 2^CNT_W.
REQ-008 clk  in  1  sole clock; all state updates occur on its rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 mode  in  1  0 = fixed round-robin, 1 = demand-actuated.
REQ-011 demand  in  N_WAY  per-approach vehicle demand, level-sensitive, used only in mode 1.
REQ-012 ped_req  in  1  pedestrian request, single-cycle pulse or level.
REQ-013 red, amber, green  out  N_WAY each  per-approach lamp drives, registered.
REQ-014 walk  out  1  pedestrian walk lamp, registered.
REQ-015 phase  out  3  current state encoding: ALL_RED=0, RED_AMBER=1, GREEN=2, AMBER=3, PED=4.

Function
REQ-016 The FSM SHALL have the states ALL_RED, RED_AMBER, GREEN, AMBER and PED, plus a 2-bit pointer ptr selecting the active approach.
REQ-017 On entering a state, the dwell counter SHALL load T_x-1; the state SHALL exit on the cycle the counter equals 0, so each state lasts exactly T_x cycles.
REQ-018 Lamp map: approaches other than ptr SHALL show red only.
REQ-019 Lamp map for approach ptr: RED_AMBER shows red+amber; GREEN shows green only; AMBER shows amber only; ALL_RED and PED show red only.
REQ-020 walk SHALL be 1 only in PED; at most one green bit SHALL be set in any cycle.
REQ-021 Transitions: RED_AMBER->GREEN, GREEN->AMBER, AMBER->ALL_RED, PED->ALL_RED, each on dwell expiry.
REQ-022 ALL_RED expiry when ped_pending=1: go to PED.
REQ-023 ALL_RED expiry when ped_pending=0 in mode 0: set ptr=(ptr+1) mod N_WAY and go to RED_AMBER.
REQ-024 ALL_RED expiry when ped_pending=0 in mode 1: search demand circularly from ptr+1 through ptr inclusive; on the first set bit, load ptr and go to RED_AMBER.
REQ-025 Mode 1 with no demand and no ped_pending: stay in ALL_RED with the counter held at 0, and re-evaluate every cycle.
REQ-026 ped_pending SHALL set on ped_req=1 in any state except PED.
REQ-027 ped_pending SHALL clear on the cycle the FSM enters PED; a ped_req sampled on that same cycle or during PED SHALL be ignored.
REQ-028 mode and demand SHALL be sampled only at ALL_RED exit; changes at any other time SHALL have no effect on the running phase.
REQ-029 ptr wrap SHALL use modulo N_WAY, never 2^2, when N_WAY<4.
REQ-030 No path from GREEN to RED_AMBER or PED that bypasses AMBER and ALL_RED SHALL exist.

Reset
REQ-031 While rst=1, asynchronously: state=ALL_RED, ptr=N_WAY-1, counter=T_ALL_RED-1, ped_pending=0, red=all ones, amber=0, green=0, walk=0, phase=0.
REQ-032 After reset release, the first green SHALL go to approach 0 in mode 0.
REQ-033 rst asserted mid-phase, including GREEN or PED, SHALL force the all-red outputs within the same cycle, without waiting for a clock edge.

Verification
REQ-034 Mode 0, N_WAY=2, defaults, no ped -> approach 0 lamps: ALL_RED 2 cycles, RED_AMBER 2, GREEN 8, AMBER 3, then ALL_RED 2 before approach 1 RED_AMBER; period 30 cycles.
REQ-035 ped_req pulsed during approach 0 GREEN -> after its AMBER and ALL_RED, walk=1 for 6 cycles with all red=1; then ALL_RED 2; then approach 1 RED_AMBER.
REQ-036 Mode 1, N_WAY=4, demand=4'b1000 only -> approach 3 serviced repeatedly; demand=0 -> held in ALL_RED with phase=0 indefinitely; demand=4'b0010 -> RED_AMBER on approach 1 the next cycle.
REQ-037 ped_req held high continuously -> PED entered after every ALL_RED; no pending set during PED; vehicle phase never starves beyond one PED per clearance.
REQ-038 rst asserted 3 cycles into GREEN -> green=0, red=all ones, phase=0 immediately; after release, the sequence restarts from approach 0 per REQ-032.
REQ-039 Every cycle of all runs: assert green is one-hot-or-zero, green&red==0, and walk implies green==0.
